ram_loader: RTL and testbench
=============================

# ram_loader

Sequential writer for the SN74x189-style tristate RAM bank on the CPU memory bus. It accepts N-bit words over a valid/ready stream and writes each one to consecutive RAM addresses starting at a programmed base. For every word it generates the address/data setup, the write-enable strobe and the hold phase, then reads the word back through the RAM's inverted output and checks it. The block sits between the front-panel/host loader path and the memory bank, and is the write-side counterpart of the CPU's read-only fetch path.

## Interface
- N, 8, data word width; the RAM bank is N/4 SN74x189 parts side by side.
- A, 4, RAM address width; DEPTH = 1<<A.
- clk  in  1  system clock; all state changes on its rising edge.
- reset_  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- base  in  A  first RAM address; sampled with start.
- len  in  A+1  number of words to load, 0..DEPTH; sampled with start.
- in_data  in  N  word to write.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the loader accepts in_data this cycle.
- ram_a  out  A  RAM address.
- ram_d  out  N  RAM write data.
- ram_cs_  out  1  RAM chip select, active-low.
- ram_we_  out  1  RAM write enable, active-low.
- ram_o_  in  N  RAM inverted read data.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when a load finishes, whether it passed or aborted.
- err  out  1  sticky verify-failure flag; cleared by the next accepted start.
- err_addr  out  A  address of the first failing word.

## Operation
- Reset values: state IDLE; in_ready=0; ram_cs_=1; ram_we_=1; ram_a=0; ram_d=0; busy=0; done=0; err=0; err_addr=0.
- FSM states: IDLE, ACCEPT, SETUP, STROBE, HOLD, CHECK.
- IDLE:
  - On start, the loader latches base into the address counter and len into the remaining-word count, and clears err.
  - If len=0, it pulses done on the next cycle and stays in IDLE.
  - Otherwise it moves to ACCEPT.
- ACCEPT:
  - in_ready=1.
  - On in_valid, the loader latches in_data into ram_d and moves to SETUP.
- SETUP: ram_cs_=0 and ram_we_=1, with ram_a and ram_d stable.
- STROBE: ram_we_=0 for exactly one cycle. The RAM captures the word on this falling edge.
- HOLD: ram_we_=1 and ram_cs_=0, with ram_a and ram_d held.
- CHECK:
  - ram_cs_=0 and ram_we_=1.
  - At the end of the cycle the loader compares ~ram_o_ with ram_d.
  - On a mismatch it sets err, latches err_addr=ram_a, pulses done and returns to IDLE. The load aborts.
  - On a match it decrements the remaining count and increments ram_a. If the count reaches 0 it pulses done and returns to IDLE; otherwise it returns to ACCEPT.
- ram_cs_ is 1 in IDLE and ACCEPT.
- ram_a wraps modulo DEPTH. For example, base=DEPTH-1 with len=2 writes addresses DEPTH-1 and then 0.
- busy=1 in every state except IDLE.
- in_ready is 0 outside ACCEPT.
- start is ignored while busy=1.
- Asserting reset_ mid-operation immediately forces ram_we_=1 and ram_cs_=1 with no clock needed. A write is never left half-strobed. The partially loaded RAM contents are undefined.

## Timing
- Handshake: a word transfers on the rising edge where in_valid && in_ready.
  - in_valid may be held or dropped freely; the upstream side must not change in_data while in_valid=1 and in_ready=0.
- Per-word latency, with the handshake at edge T:
  - SETUP during cycle T..T+1.
  - STROBE during T+1..T+2.
  - HOLD during T+2..T+3.
  - CHECK during T+3..T+4.
  - in_ready is reasserted in the cycle after T+4.
- Peak throughput is one word every 5 cycles.
- done is asserted in the cycle after the final CHECK.
- ram_a and ram_d change only in IDLE/ACCEPT or on CHECK exit, never while ram_cs_=0. This gives at least one cycle of setup and one cycle of hold around the we_ strobe.

## Structure
- Shared package kwan_pkg holds:
  - the loader_state_t enum (IDLE, ACCEPT, SETUP, STROBE, HOLD, CHECK);
  - the constant LOADER_WORD_CYCLES=5.
- Natural sub-module: SN74x161, a 4-bit synchronous loadable binary counter with enable and a ripple-carry output. It is used for ram_a, cascaded when A>4.
- The remaining-word counter and the FSM are inline.

## Test plan
- Basic load: reset, then start with base=0 and len=3, streaming 8'hA5, 8'h3C, 8'hFF with in_valid held high. Required: the RAM holds A5/3C/FF at addresses 0/1/2; done is pulsed 15 cycles after the first handshake; err=0.
- Wrap-around: base=15 and len=2 with data 8'h11 and 8'h22. Required: RAM[15]=8'h11 and RAM[0]=8'h22, with ram_a wrapping from 15 to 0.
- Zero length: start with len=0. Required: done pulses on the next cycle; busy never rises; ram_cs_ stays 1.
- Verify failure: force RAM bit 0 stuck at 0 in the behavioural model, then load 8'h01 at base=4. Required: err=1, err_addr=4, done pulsed; subsequent words are not accepted.
- Backpressure and ignored start: drop in_valid for 7 cycles between words and pulse start while busy. Required: the FSM waits in ACCEPT with ram_cs_=1; the second start has no effect; the data is still written correctly.
- Reset mid-strobe: assert reset_ low during STROBE. Required: ram_we_=1 and ram_cs_=1 in the same cycle; busy=0; then a fresh load succeeds.

Source files
------------

// File: rtl/kwan_pkg.sv
// Shared definitions for the RAM loader: FSM state encoding, word timing
// and the counter-stage sizing helper.
package kwan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        SETUP,
        STROBE,
        HOLD,
        CHECK
    } loader_state_t;

    // Cycles spent per word at peak rate: ACCEPT, SETUP, STROBE, HOLD, CHECK.
    localparam int LOADER_WORD_CYCLES = 5;

    // Number of 4-bit counter parts needed to cover an a-bit address.
    function automatic int ctr_stages(input int a);
        return (a + 3) / 4;
    endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Loader bus bundle: upstream word stream plus the SN74x189 bank pins.
// master = the loader, slave = the stream source / RAM bank side.
interface ram_loader_if #(
    parameter int N = 8,
    parameter int A = 4
);
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [A-1:0] ram_a;
    logic [N-1:0] ram_d;
    logic         ram_cs_;
    logic         ram_we_;
    logic [N-1:0] ram_o_;

    modport master (
        input  in_data, in_valid, ram_o_,
        output in_ready, ram_a, ram_d, ram_cs_, ram_we_
    );

    modport slave (
        output in_data, in_valid, ram_o_,
        input  in_ready, ram_a, ram_d, ram_cs_, ram_we_
    );
endinterface

// File: rtl/ram_loader_sn74x161.sv
// SN74x161 model: 4-bit synchronous binary counter with async clear,
// synchronous active-low load, ENP/ENT count enables and ripple carry out.
module sn74x161 (
    input  logic       clk,
    input  logic       clr_,
    input  logic       load_,
    input  logic       enp,
    input  logic       ent,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       rco
);

    // Load has priority over counting; both enables must be high to count.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_)
            q <= '0;
        else if (!load_)
            q <= d;
        else if (enp && ent)
            q <= q + 4'd1;
    end

    assign rco = ent && (q == 4'hF);

endmodule

// File: rtl/ram_loader.sv
// Sequential writer for an SN74x189 RAM bank: takes words from a
// valid/ready stream, writes them to consecutive addresses with explicit
// setup / strobe / hold phases, and verifies each one via the inverted
// read port. A verify failure aborts the load and records the address.
module ram_loader
    import kwan_pkg::*;
#(
    parameter int N = 8,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         start,
    input  logic [A-1:0] base,
    input  logic [A:0]   len,
    ram_loader_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [A-1:0] err_addr
);

    localparam int NC = ctr_stages(A);
    localparam int AW = 4 * NC;

    loader_state_t state, state_nxt;
    logic [A:0]    remain;
    logic          ld, inc, mismatch, last;
    logic [AW-1:0] base_ext, a_q;
    logic [NC:0]   ent;
    logic          unused_bits;

    // The RAM drives inverted data; compare against what we wrote.
    assign mismatch = ((~bus.ram_o_) != bus.ram_d);
    assign last     = (remain == (A+1)'(1));

    // Zero-extend base to the full cascaded counter width.
    always_comb begin
        base_ext        = '0;
        base_ext[A-1:0] = base;
    end

    // Address counter: cascaded '161s, carry rippling through ENT.
    // Bits above A (if any) are ignored, so the address wraps mod DEPTH.
    assign ent[0] = inc;
    generate
        for (genvar i = 0; i < NC; i++) begin : g_ctr
            sn74x161 u_ctr (
                .clk   (clk),
                .clr_  (reset_),
                .load_ (~ld),
                .enp   (inc),
                .ent   (ent[i]),
                .d     (base_ext[4*i +: 4]),
                .q     (a_q[4*i +: 4]),
                .rco   (ent[i+1])
            );
        end
    endgenerate

    assign bus.ram_a   = a_q[A-1:0];
    assign unused_bits = ^{ent[NC], a_q};

    // State register; reset lands in IDLE so cs_/we_ deassert immediately.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && len != '0) state_nxt = ACCEPT;
            ACCEPT:  if (bus.in_valid) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  state_nxt = HOLD;
            HOLD:    state_nxt = CHECK;
            CHECK:   state_nxt = (mismatch || last) ? IDLE : ACCEPT;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; cs_/we_ are fully determined by state
    // so an async reset drops them without waiting for a clock.
    always_comb begin
        bus.in_ready = (state == ACCEPT);
        bus.ram_cs_  = !(state == SETUP || state == STROBE ||
                         state == HOLD  || state == CHECK);
        bus.ram_we_  = (state != STROBE);
        busy         = (state != IDLE);
        ld           = (state == IDLE) && start;
        inc          = (state == CHECK) && !mismatch;
    end

    // Datapath: word count, write data, error capture and done pulse.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            remain    <= '0;
            bus.ram_d <= '0;
            err       <= 1'b0;
            err_addr  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == IDLE && start && len == '0) ||
                    (state == CHECK && (mismatch || last));
            if (state == IDLE && start) begin
                remain <= len;
                err    <= 1'b0;
            end
            if (state == ACCEPT && bus.in_valid)
                bus.ram_d <= bus.in_data;
            if (state == CHECK) begin
                if (mismatch) begin
                    err      <= 1'b1;
                    err_addr <= bus.ram_a;
                end else begin
                    remain <= remain - (A+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: behavioural SN74x189 bank with optional stuck-at-0
// bits, a load-level reference model feeding scoreboard queues, and a
// monitor that checks every strobe and every done pulse against them.
module tb_ram_loader;
    import kwan_pkg::*;

    localparam int N     = 8;
    localparam int A     = 4;
    localparam int DEPTH = 1 << A;

    typedef struct packed { logic [A-1:0] a; logic [N-1:0] d; } wr_t;
    typedef struct packed { logic e; logic [A-1:0] a; } dn_t;

    logic         clk = 1'b0;
    logic         reset_ = 1'b0;
    logic         start = 1'b0;
    logic [A-1:0] base = '0;
    logic [A:0]   len = '0;
    logic         busy, done, err;
    logic [A-1:0] err_addr;

    ram_loader_if #(.N(N), .A(A)) bus ();

    ram_loader #(.N(N), .A(A)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .start    (start),
        .base     (base),
        .len      (len),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    logic [N-1:0] mem [DEPTH];
    logic [N-1:0] stuck0 = '0;
    logic [N-1:0] wq [$];
    wr_t          exp_wr [$];
    dn_t          exp_dn [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no DUT event within bound, want event", name);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM bank: captures on the falling edge of we_ while selected.
    initial forever begin
        @(negedge bus.ram_we_);
        if (reset_ && !bus.ram_cs_)
            mem[bus.ram_a] = bus.ram_d & ~stuck0;
    end

    assign bus.ram_o_ = (!bus.ram_cs_ && bus.ram_we_) ? ~mem[bus.ram_a] : '1;

    // Monitor: compares strobes and done pulses against the scoreboard.
    initial begin : monitor
        wr_t          w;
        dn_t          e;
        logic         prev_cs = 1'b1;
        logic [A-1:0] prev_a = '0;
        logic [N-1:0] prev_d = '0;
        forever begin
            @(negedge clk);
            if (!reset_) begin
                prev_cs = 1'b1;
                continue;
            end
            if (!bus.ram_we_) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                             bus.ram_a, bus.ram_d);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", bus.ram_a, w.a);
                    chk("wr_data", bus.ram_d, w.d);
                    chk("wr_cs", bus.ram_cs_, 1'b0);
                end
            end
            if (!bus.ram_cs_ && !prev_cs) begin
                chk("addr_stable_cs", bus.ram_a, prev_a);
                chk("data_stable_cs", bus.ram_d, prev_d);
            end
            if (bus.in_ready) chk("cs_in_accept", bus.ram_cs_, 1'b1);
            if (!busy) chk("cs_idle", bus.ram_cs_, 1'b1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_dn.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1, want done=0");
                end else begin
                    e = exp_dn.pop_front();
                    chk("done_err", err, e.e);
                    if (e.e) chk("done_err_addr", err_addr, e.a);
                end
            end
            prev_cs = bus.ram_cs_;
            prev_a  = bus.ram_a;
            prev_d  = bus.ram_d;
        end
    end

    // Runs one load of the words in wq. The model predicts which words are
    // written (a word whose value loses a stuck bit is the last one) and how
    // the load ends; the driver then streams the words with random gaps.
    task automatic do_load(input logic [A-1:0] b, input int l, input int gmin, input int gmax,
                           input logic [N-1:0] stuck, input bit bad_start,
                           output int first_hs, output int last_hs);
        int           nacc, d0, gap;
        bit           fail, aborted, got;
        logic [A-1:0] a;
        wr_t          w;
        dn_t          e;
        stuck0 = stuck; nacc = l; fail = 0; first_hs = -1; last_hs = -1;
        for (int i = 0; i < l; i++) begin
            a = A'((int'(b) + i) % DEPTH);
            w.a = a; w.d = wq[i];
            exp_wr.push_back(w);
            if ((wq[i] & ~stuck) != wq[i]) begin
                e.e = 1'b1; e.a = a;
                exp_dn.push_back(e);
                nacc = i + 1; fail = 1;
                break;
            end
        end
        if (!fail) begin
            e.e = 1'b0; e.a = '0;
            exp_dn.push_back(e);
        end
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; base = b; len = (A+1)'(l);
        @(posedge clk); #1;
        start = 1'b0;
        if (l == 0) begin
            chk("zero_len_done", done, 1'b1);
            chk("zero_len_busy", busy, 1'b0);
            chk("zero_len_cs", bus.ram_cs_, 1'b1);
            repeat (3) begin
                @(negedge clk); #1;
                chk("zero_len_busy_after", busy, 1'b0);
                chk("zero_len_cs_after", bus.ram_cs_, 1'b1);
            end
            chk("zero_len_done_count", done_cnt - d0, 1);
            return;
        end
        aborted = 0;
        for (int i = 0; i < l && !aborted; i++) begin
            gap = $urandom_range(gmax, gmin);
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                if (bad_start && i == 1 && g == 2) begin
                    start = 1'b1; base = ~b; len = '0;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (gap >= LOADER_WORD_CYCLES) begin
                chk("wait_accept_ready", bus.in_ready, 1'b1);
                chk("wait_accept_cs", bus.ram_cs_, 1'b1);
            end
            bus.in_data = wq[i]; bus.in_valid = 1'b1; got = 0;
            for (int t = 0; t < 40 && !got && !aborted; t++) begin
                @(negedge clk); #1;
                if (done_cnt != d0) aborted = 1;
                else if (bus.in_ready) begin
                    @(posedge clk); #1;
                    got = 1;
                end
            end
            if (got) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end else if (!aborted) begin
                timeout("handshake");
            end
        end
        if (aborted) begin
            repeat (4) begin
                @(negedge clk); #1;
                chk("no_accept_after_abort", bus.in_ready, 1'b0);
            end
        end
        bus.in_valid = 1'b0;
        for (int t = 0; t < 30 && done_cnt == d0; t++) begin
            @(negedge clk); #1;
        end
        if (done_cnt == d0) begin
            timeout("done");
        end else begin
            chk("done_latency", done_cyc - last_hs, 4);
            chk("busy_after_done", busy, 1'b0);
            chk("single_done", done_cnt - d0, 1);
        end
        for (int i = 0; i < nacc; i++) begin
            a = A'((int'(b) + i) % DEPTH);
            chk("ram_content", mem[a], wq[i] & ~stuck);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int           f_hs, l_hs, l;
        bit           got;
        logic [A-1:0] b;
        logic [N-1:0] st;
        foreach (mem[i]) mem[i] = '0;
        bus.in_data = '0; bus.in_valid = 1'b0;

        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_cs", bus.ram_cs_, 1'b1);
        chk("rst_we", bus.ram_we_, 1'b1);
        chk("rst_ram_a", bus.ram_a, 0);
        chk("rst_ram_d", bus.ram_d, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_addr", err_addr, 0);
        reset_ = 1'b1;

        // Basic load, in_valid held: words every 5 cycles, done in the 15th
        // cycle counting the first handshake's SETUP cycle as cycle 1.
        wq = '{8'hA5, 8'h3C, 8'hFF};
        do_load(4'd0, 3, 0, 0, '0, 0, f_hs, l_hs);
        chk("basic_done_cycle", done_cyc - f_hs, 14);
        chk("basic_throughput", l_hs - f_hs, 2 * LOADER_WORD_CYCLES);
        chk("basic_err", err, 1'b0);

        // Address wrap 15 -> 0.
        wq = '{8'h11, 8'h22};
        do_load(4'd15, 2, 0, 0, '0, 0, f_hs, l_hs);

        // Zero length.
        wq.delete();
        do_load(4'd3, 0, 0, 0, '0, 0, f_hs, l_hs);

        // Verify failure: bit 0 stuck low, first word needs it.
        wq = '{8'h01, 8'h02, 8'h03};
        do_load(4'd4, 3, 0, 0, 8'h01, 0, f_hs, l_hs);
        chk("verify_err", err, 1'b1);
        chk("verify_err_addr", err_addr, 4);

        // Backpressure with 7-cycle gaps and a start pulse while busy.
        wq = '{8'h5E, 8'hC3, 8'h81};
        do_load(4'd9, 3, 7, 7, '0, 1, f_hs, l_hs);
        chk("err_cleared_by_start", err, 1'b0);

        // Full depth from a non-zero base.
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back(N'(8'h30 + i));
        do_load(4'd5, DEPTH, 0, 1, '0, 0, f_hs, l_hs);

        // Reset asserted during STROBE.
        begin
            wr_t w;
            w.a = 4'd7; w.d = 8'h5A;
            exp_wr.push_back(w);
            @(posedge clk); #1;
            start = 1'b1; base = 4'd7; len = 5'd1;
            @(posedge clk); #1;
            start = 1'b0; bus.in_data = 8'h5A; bus.in_valid = 1'b1;
            got = 0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk); #1;
                if (!bus.ram_we_) got = 1;
            end
            if (!got) timeout("reach_strobe");
            reset_ = 1'b0;
            #1;
            chk("midrst_we", bus.ram_we_, 1'b1);
            chk("midrst_cs", bus.ram_cs_, 1'b1);
            chk("midrst_busy", busy, 1'b0);
            chk("midrst_in_ready", bus.in_ready, 1'b0);
            bus.in_valid = 1'b0;
            @(posedge clk); @(posedge clk); #1;
            reset_ = 1'b1;
            chk("midrst_sb_drained", exp_wr.size(), 0);
        end
        wq = '{8'hDE, 8'hAD};
        do_load(4'd7, 2, 0, 2, '0, 0, f_hs, l_hs);

        // Randomized loads, some with a stuck bit in the bank.
        for (int r = 0; r < 12; r++) begin
            l = $urandom_range(DEPTH, 1);
            b = A'($urandom_range(DEPTH - 1, 0));
            st = ($urandom_range(3, 0) == 0) ? N'(1 << $urandom_range(N - 1, 0)) : '0;
            wq.delete();
            for (int i = 0; i < l; i++) wq.push_back(N'($urandom));
            do_load(b, l, 0, 3, st, 0, f_hs, l_hs);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("final_wr_queue_empty", exp_wr.size(), 0);
        chk("final_done_queue_empty", exp_dn.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
